// File: rtl/mdu.sv
// mdu: RV32M multiply/divide unit with a fixed-latency bit-serial datapath.
// Ports:  clk            - sole clock, rising edge
//         resetn         - synchronous reset, active HIGH despite the name
//         start          - request an operation; sampled only while idle
//         funct3[2:0]    - MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//         x, y[XLEN-1:0] - operands rs1, rs2
//         busy           - high in RUN and DONE
//         done           - one-cycle pulse, out valid in that cycle
//         out[XLEN-1:0]  - registered result, held until the next done
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier
// (multiplies go IDLE -> DONE); divides always take the iterative path.
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic neg_q, neg_d;
    logic [XLEN-1:0] a_q, a_d, q_q, q_d, r_q, r_d, out_q, out_d;
    logic x_sgn, y_sgn, xs, ys, ok;
    logic [XLEN-1:0] xm, ym, res;
    logic [XLEN:0] msum, rsh;
    logic [2*XLEN-1:0] prod, pres;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod;
    always_comb fprod = {{XLEN{xs}}, x} * {{XLEN{ys}}, y};
`endif
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            q_q     <= q_d;
            r_q     <= r_d;
            out_q   <= out_d;
        end
    end
    // a holds the multiplicand/divisor magnitude, q the multiplier/dividend
    // (shifted out as the product low half / quotient), r the high half/remainder.
    always_comb begin
        x_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        y_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
        xs    = x_sgn && x[XLEN-1];
        ys    = y_sgn && y[XLEN-1];
        xm    = xs ? -x : x;
        ym    = ys ? -y : y;
        msum  = {1'b0, r_q} + {1'b0, (q_q[0] ? a_q : {XLEN{1'b0}})};
        rsh   = {r_q, q_q[XLEN-1]};
        ok    = rsh >= {1'b0, a_q};
        prod  = {r_q, q_q};
        pres  = neg_q ? -prod : prod;
        res   = !op_q[2] ? ((op_q[1:0] == 2'b00) ? pres[XLEN-1:0] : pres[2*XLEN-1:XLEN])
              : op_q[1]  ? (neg_q ? -r_q : r_q)
              :            (neg_q ? -q_q : q_q);
    end
    // Divide-by-zero quotient must stay all-ones, so it is never negated;
    // the overflow case falls out of the magnitude arithmetic unaided.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_d     = a_q;
        q_d     = q_q;
        r_d     = r_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = CW'(XLEN);
                op_d    = funct3;
                neg_d   = funct3[2] ? (funct3[1] ? xs : ((xs ^ ys) && (y != '0))) : (xs ^ ys);
                a_d     = funct3[2] ? ym : xm;
                q_d     = funct3[2] ? xm : ym;
                r_d     = '0;
`ifdef MDU_FAST_MUL_EN
                if (!funct3[2]) begin
                    state_d = DONE;
                    out_d   = (funct3[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
                end
`endif
            end
            RUN: if (cnt_q == '0) begin
                state_d = DONE;
                out_d   = res;
            end else begin
                cnt_d = cnt_q - 1'b1;
                r_d   = !op_q[2] ? msum[XLEN:1] : (ok ? rsh[XLEN-1:0] - a_q : rsh[XLEN-1:0]);
                q_d   = !op_q[2] ? {msum[0], q_q[XLEN-1:1]} : {q_q[XLEN-2:0], ok};
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
        out  = out_q;
    end
endmodule
